pc_tick_ctrl: RTL and testbench
===============================

# pc_tick_ctrl

Run-control stage directly upstream of the PC register: generates the `Tick` and `ClockEnable` strobes that gate every PC update. It supports free-run with a programmable tick divider, single-step from a pushbutton-style request, and halt on an ecall/halt indication from decode. It also counts the ticks it issues for the board display.

## Interface
Parameters:
- `DIV_BITS`, 8, width of tick divisor and divider counter
- `CNT_BITS`, 32, width of issued-tick counter

Ports:
- `Clock`  in  1  single system clock; all logic on its rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Run`  in  1  level; 1 = free-run requested
- `Step`  in  1  single-step request; rising edge detected internally
- `Halt`  in  1  level from decode (ecall/halt); forces halted state
- `Resume`  in  1  level; leaves halted state
- `Divisor`  in  DIV_BITS  one tick every `Divisor`+1 cycles in RUN
- `Tick`  out  1  one-cycle PC-advance strobe
- `ClockEnable`  out  1  high while in RUN or STEP
- `Halted`  out  1  high while in HALT
- `CycleCount`  out  CNT_BITS  number of Tick pulses issued

## Operation
- All outputs are registered. Reset sets the state to IDLE and clears `Tick`, `ClockEnable`, `Halted`, the divider counter, `CycleCount` and the step-edge register to 0.
- `step_edge = Step & ~step_q`; `step_q` is updated every cycle, including in HALT.
- States: IDLE, RUN, STEP, HALT. Priority within any state: Halt > Run > step_edge.
- IDLE:
  - Halt → HALT
  - Run → RUN, with divider cleared
  - step_edge → STEP with `Tick` set to 1
  - otherwise remain in IDLE
- RUN, no Halt:
  - Divider match is `div_cnt >= Divisor`. The `>=` covers `Divisor` shrinking mid-run.
  - On match: `Tick`←1 and `div_cnt`←0.
  - Otherwise: `Tick`←0 and `div_cnt`←`div_cnt`+1.
  - If Run=0: go to IDLE with `Tick`←0 and the divider cleared.
  - step_edge is ignored in RUN.
- STEP: unconditionally return to IDLE (or to HALT if Halt=1) with `Tick`←0. Exactly one Tick is issued per step.
- HALT:
  - `Tick`=0, `ClockEnable`=0, `Halted`=1.
  - Resume=1 → IDLE with `Halted`←0.
  - Run and step_edge are ignored.
  - If Halt and Resume are both 1, remain in HALT.
- Halt seen in RUN or STEP suppresses any Tick due on that edge; `Tick`←0.
- `ClockEnable` takes the registered value of next-state ∈ {RUN, STEP}.
- `CycleCount` ← `CycleCount` + next-Tick, wrapping modulo 2^CNT_BITS. It is therefore updated on the same edge as the Tick it counts.

## Timing
- Step: step_edge sampled at edge n → `Tick`=1 and `ClockEnable`=1 during cycle n..n+1 → both 0 after edge n+1.
- Run: Run sampled at edge n → state RUN, `Tick`=0. First Tick is driven by edge n+1+`Divisor`. Thereafter the Tick period is `Divisor`+1 cycles.
- `Divisor`=0 → Tick high every cycle in RUN after the first entry cycle.
- Halt: one-cycle latency to `Halted`=1. No Tick is produced on or after the edge that samples Halt.
- Resume: one-cycle latency to `Halted`=0. A new Run or Step is needed to restart.
- Reset mid-operation wins over every input on that edge.

## Configuration
- `PC_TICK_COUNT_EN` defined: `CycleCount` counter is implemented as described.
- `PC_TICK_COUNT_EN` undefined: no counter flops are built, and `CycleCount` is tied to 0.

## Structure
- Shared package `pc_ctrl_pkg`:
  - state typedef: IDLE=2'd0, RUN=2'd1, STEP=2'd2, HALT=2'd3
  - default widths for `DIV_BITS` and `CNT_BITS`
- One sub-module, `pc_tick_divider`, containing the divider counter, the `>=` compare and the clear input; it outputs the match strobe.
- The FSM, step edge detection, output registers and `CycleCount` live in the top level.

## Test plan
- Reset held 2 cycles with Run=1 → all outputs 0. After release, first Tick appears 1+`Divisor` cycles after RUN entry.
- `Divisor`=3, Run=1 for 20 cycles → Tick every 4 cycles, each pulse 1 cycle wide. `CycleCount` matches the pulse count (4 or 5 depending on alignment; the checker counts pulses).
- Run=0, Step held high 10 cycles → exactly one Tick, on the cycle after the rising edge. A second rising edge gives a second Tick.
- RUN with Halt asserted on the cycle the divider matches → no Tick, `Halted`=1 next cycle. Run and Step ignored until Resume=1; after Resume, `Halted`=0.
- `Divisor` changed 7→2 while `div_cnt`=5 → Tick on the next edge, then a period of 3.
- `CNT_BITS`=4, 17 ticks → `CycleCount`=1 (wrap). Build without `PC_TICK_COUNT_EN` → `CycleCount` stays 0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and default widths for the PC run-control slice.
package pc_ctrl_pkg;

    localparam int DIV_BITS_DEF = 8;
    localparam int CNT_BITS_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_e;

    function automatic logic is_enabled(state_e s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/pc_tick_divider.sv
// Free-run tick divider: counts up to Divisor and flags a match.
module pc_tick_divider
    import pc_ctrl_pkg::*;
#(
    parameter int DIV_BITS = DIV_BITS_DEF
) (
    input  logic                Clock,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [DIV_BITS-1:0] divisor_i,
    output logic                match_o
);

    logic [DIV_BITS-1:0] div_cnt_q;
    logic [DIV_BITS-1:0] div_cnt_d;

    // >= rather than == so a shrinking divisor never strands the count
    assign match_o = (div_cnt_q >= divisor_i);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear_i) begin
            div_cnt_d = '0;
        end else if (en_i) begin
            div_cnt_d = match_o ? '0 : div_cnt_q + DIV_BITS'(1);
        end
    end

    always_ff @(posedge Clock) begin
        div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/pc_tick_ctrl.sv
// PC run control: free-run, single-step and halt; drives Tick/ClockEnable.
// Define PC_TICK_COUNT_EN to build the issued-tick counter CycleCount.
module pc_tick_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int DIV_BITS = DIV_BITS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic                Step,
    input  logic                Halt,
    input  logic                Resume,
    input  logic [DIV_BITS-1:0] Divisor,
    output logic                Tick,
    output logic                ClockEnable,
    output logic                Halted,
    output logic [CNT_BITS-1:0] CycleCount
);

    state_e state_q;
    state_e state_d;
    logic   tick_q;
    logic   tick_d;
    logic   ce_q;
    logic   halted_q;
    logic   step_q;
    logic   step_edge;
    logic   div_en;
    logic   div_match;

    assign step_edge = Step & ~step_q;
    assign div_en    = (state_q == RUN) & Run & ~Halt;

    pc_tick_divider #(
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .Clock     (Clock),
        .clear_i   (Reset | ~div_en),
        .en_i      (div_en),
        .divisor_i (Divisor),
        .match_o   (div_match)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (Run) begin
                    state_d = RUN;
                end else if (step_edge) begin
                    state_d = STEP;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (!Run) begin
                    state_d = IDLE;
                end else begin
                    tick_d = div_match;
                end
            end
            STEP: begin
                state_d = Halt ? HALT : IDLE;
            end
            HALT: begin
                if (Resume && !Halt) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            tick_q   <= 1'b0;
            ce_q     <= 1'b0;
            halted_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            ce_q     <= is_enabled(state_d);
            halted_q <= (state_d == HALT);
            step_q   <= Step;
        end
    end

    assign Tick        = tick_q;
    assign ClockEnable = ce_q;
    assign Halted      = halted_q;

`ifdef PC_TICK_COUNT_EN
    logic [CNT_BITS-1:0] cnt_q;

    // counts on the same edge that raises the Tick it counts
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_BITS'(tick_d);
        end
    end

    assign CycleCount = cnt_q;
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_pc_tick_ctrl.sv
// Directed bench for pc_tick_ctrl with a 4-bit tick counter.
module tb_pc_tick_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Run;
    logic       Step;
    logic       Halt;
    logic       Resume;
    logic [7:0] Divisor;
    logic       Tick;
    logic       ClockEnable;
    logic       Halted;
    logic [3:0] CycleCount;

    int checks    = 0;
    int errors    = 0;
    int exp_ticks = 0;

    pc_tick_ctrl #(
        .DIV_BITS (8),
        .CNT_BITS (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Run         (Run),
        .Step        (Step),
        .Halt        (Halt),
        .Resume      (Resume),
        .Divisor     (Divisor),
        .Tick        (Tick),
        .ClockEnable (ClockEnable),
        .Halted      (Halted),
        .CycleCount  (CycleCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic tick_chk(string tag, logic exp);
        check(tag, {31'b0, Tick}, {31'b0, exp});
        if (exp) exp_ticks++;
    endtask

    task automatic cnt_chk(string tag);
        logic [31:0] e;
`ifdef PC_TICK_COUNT_EN
        e = exp_ticks % 16;
`else
        e = 0;
`endif
        check(tag, {28'b0, CycleCount}, e);
    endtask

    task automatic outs_chk(string tag, logic t, logic ce, logic h);
        tick_chk({tag, "_tick"}, t);
        check({tag, "_ce"}, {31'b0, ClockEnable}, {31'b0, ce});
        check({tag, "_halt"}, {31'b0, Halted}, {31'b0, h});
    endtask

    initial begin
        Reset   = 1'b1;
        Run     = 1'b1;
        Step    = 1'b0;
        Halt    = 1'b0;
        Resume  = 1'b0;
        Divisor = 8'd3;
        cyc();
        cyc();
        outs_chk("rst", 1'b0, 1'b0, 1'b0);
        cnt_chk("rst_cnt");

        // free run, divisor 3
        Reset = 1'b0;
        cyc();
        outs_chk("run_entry", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            tick_chk("run_d3", (i % 4) == 0);
        end
        cnt_chk("run_cnt");
        Run = 1'b0;
        cyc();
        outs_chk("run_stop", 1'b0, 1'b0, 1'b0);

        // single step, held high
        Step = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            tick_chk("step", i == 1);
            check("step_ce", {31'b0, ClockEnable}, {31'b0, i == 1});
        end
        Step = 1'b0;
        cyc();
        tick_chk("step_low", 1'b0);
        Step = 1'b1;
        cyc();
        outs_chk("step2", 1'b1, 1'b1, 1'b0);
        Step = 1'b0;
        cyc();
        tick_chk("step2_end", 1'b0);

        // halt on the matching edge
        Divisor = 8'd1;
        Run = 1'b1;
        cyc();
        tick_chk("h_entry", 1'b0);
        cyc();
        tick_chk("h_cnt0", 1'b0);
        Halt = 1'b1;
        cyc();
        outs_chk("halt", 1'b0, 1'b0, 1'b1);
        Halt = 1'b0;
        Step = 1'b1;
        cyc();
        outs_chk("halt_ign1", 1'b0, 1'b0, 1'b1);
        Step = 1'b0;
        cyc();
        Step = 1'b1;
        cyc();
        outs_chk("halt_ign2", 1'b0, 1'b0, 1'b1);
        Halt = 1'b1;
        Resume = 1'b1;
        cyc();
        outs_chk("halt_both", 1'b0, 1'b0, 1'b1);
        Halt = 1'b0;
        Run = 1'b0;
        Step = 1'b0;
        cyc();
        outs_chk("resume", 1'b0, 1'b0, 1'b0);
        Resume = 1'b0;
        cnt_chk("halt_cnt");

        // divisor shrinks 7 -> 2 with count at 5
        Divisor = 8'd7;
        Run = 1'b1;
        cyc();
        tick_chk("dv_entry", 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            tick_chk("dv_pre", 1'b0);
        end
        Divisor = 8'd2;
        for (int i = 6; i <= 12; i++) begin
            cyc();
            tick_chk("dv_post", (i == 6) || (i == 9) || (i == 12));
        end
        Run = 1'b0;
        cyc();
        tick_chk("dv_stop", 1'b0);

        // divisor 0: tick every cycle after entry, count wraps at 16
        Divisor = 8'd0;
        Run = 1'b1;
        cyc();
        outs_chk("d0_entry", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cyc();
            tick_chk("d0", 1'b1);
        end
        cnt_chk("wrap_cnt");

        // reset mid-run
        Reset = 1'b1;
        cyc();
        exp_ticks = 0;
        outs_chk("rst_mid", 1'b0, 1'b0, 1'b0);
        cnt_chk("rst_mid_cnt");
        Reset = 1'b0;
        cyc();
        outs_chk("d0_reentry", 1'b0, 1'b1, 1'b0);
        cyc();
        tick_chk("d0_tick", 1'b1);
        Halt = 1'b1;
        cyc();
        outs_chk("d0_halt", 1'b0, 1'b0, 1'b1);
        cnt_chk("end_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
